// File: rtl/vc_credit_tx.sv
// ============================================================================
// vc_credit_tx : credit-based link transmitter with per-VC packet tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module vc_credit_tx #(
   parameter int NUM_VC    = 2,
   parameter int FLIT_W    = 16,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_vc,
   input  logic              in_head,
   input  logic              in_tail,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_vc,
   output logic              out_head,
   output logic              out_tail,
   output logic [FLIT_W-1:0] out_flit,
   input  logic              credit_valid,
   input  logic              credit_vc,
   output logic [CNT_W-1:0]  credit_cnt0,
   output logic [CNT_W-1:0]  credit_cnt1,
   output logic [NUM_VC-1:0] vc_busy,
   output logic              credit_err,
   output logic              proto_err
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } vc_state_t;

   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BUF_DEPTH);

   vc_state_t         r_state     [NUM_VC];
   vc_state_t         w_state_nxt [NUM_VC];
   logic [CNT_W-1:0]  r_cnt       [NUM_VC];

   logic              w_legal;
   logic              w_accept;
   logic              w_illegal;
   logic [NUM_VC-1:0] w_acc_vc;
   logic [NUM_VC-1:0] w_ret_vc;
   logic [NUM_VC-1:0] w_full;

   // A head may only open an idle VC; body/tail flits must continue an open one.
   always_comb begin
      w_legal   = in_head ? (r_state[in_vc] == ST_IDLE) : (r_state[in_vc] == ST_ACTIVE);
      in_ready  = (r_cnt[in_vc] != '0) && w_legal;
      w_accept  = in_valid && in_ready;
      w_illegal = in_valid && !w_legal;
   end

   always_comb begin
      w_acc_vc = '0;
      w_ret_vc = '0;
      w_full   = '0;
      vc_busy  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_acc_vc[v] = w_accept && (int'(in_vc) == v);
         w_ret_vc[v] = credit_valid && (int'(credit_vc) == v);
         w_full[v]   = (r_cnt[v] == C_FULL);
         vc_busy[v]  = (r_state[v] == ST_ACTIVE);
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         w_state_nxt[v] = r_state[v];
         case (r_state[v])
            ST_IDLE:   if (w_acc_vc[v] && in_head && !in_tail) w_state_nxt[v] = ST_ACTIVE;
            ST_ACTIVE: if (w_acc_vc[v] && in_tail)             w_state_nxt[v] = ST_IDLE;
            default:   w_state_nxt[v] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_state[v] <= ST_IDLE;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_state[v] <= w_state_nxt[v];
         end
      end
   end

   // Simultaneous send and return on one VC cancel; a return into a full
   // counter is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_cnt[v] <= C_FULL;
         end
         credit_err <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            case ({w_acc_vc[v], w_ret_vc[v]})
               2'b10:   r_cnt[v] <= r_cnt[v] - CNT_W'(1);
               2'b01:   if (!w_full[v]) r_cnt[v] <= r_cnt[v] + CNT_W'(1);
               default: r_cnt[v] <= r_cnt[v];
            endcase
         end
         if (|(w_ret_vc & ~w_acc_vc & w_full)) credit_err <= 1'b1;
         if (w_illegal)                        proto_err  <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_vc    <= 1'b0;
         out_head  <= 1'b0;
         out_tail  <= 1'b0;
         out_flit  <= '0;
      end else begin
         out_valid <= w_accept;
         if (w_accept) begin
            out_vc   <= in_vc;
            out_head <= in_head;
            out_tail <= in_tail;
            out_flit <= in_flit;
         end
      end
   end

   assign credit_cnt0 = r_cnt[0];
   assign credit_cnt1 = r_cnt[1];

endmodule

`default_nettype wire

// File: tb/tb_vc_credit_tx.sv
// ============================================================================
// tb_vc_credit_tx : scoreboard bench for vc_credit_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vc_credit_tx;

   localparam int FLIT_W = 16;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_vc, in_head, in_tail;
   logic [FLIT_W-1:0] in_flit;
   logic              in_ready;
   logic              out_valid, out_vc, out_head, out_tail;
   logic [FLIT_W-1:0] out_flit;
   logic              credit_valid, credit_vc;
   logic [CNT_W-1:0]  credit_cnt0, credit_cnt1;
   logic [1:0]        vc_busy;
   logic              credit_err, proto_err;

   typedef struct packed {
      logic              vc;
      logic              head;
      logic              tail;
      logic [FLIT_W-1:0] flit;
   } flit_t;

   flit_t sb_q[$];
   int    m_cnt[2];
   bit    m_busy[2];
   int    checks = 0;
   int    errors = 0;

   vc_credit_tx #(.NUM_VC(2), .FLIT_W(FLIT_W), .BUF_DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail),
      .in_flit(in_flit), .in_ready(in_ready),
      .out_valid(out_valid), .out_vc(out_vc), .out_head(out_head), .out_tail(out_tail),
      .out_flit(out_flit),
      .credit_valid(credit_valid), .credit_vc(credit_vc),
      .credit_cnt0(credit_cnt0), .credit_cnt1(credit_cnt1),
      .vc_busy(vc_busy), .credit_err(credit_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Link monitor: every accepted flit must appear exactly one cycle later.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (sb_q.size() > 0) begin
            flit_t e;
            e = sb_q.pop_front();
            if (out_valid !== 1'b1 || {out_vc, out_head, out_tail, out_flit} !== e) begin
               errors++;
               $display("FAIL link_flit got valid=%b vc=%b h=%b t=%b flit=%h want vc=%b h=%b t=%b flit=%h",
                        out_valid, out_vc, out_head, out_tail, out_flit, e.vc, e.head, e.tail, e.flit);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL link_idle got out_valid=%b want 0", out_valid);
         end
      end
   end

   task automatic model_reset();
      m_cnt[0] = 4; m_cnt[1] = 4;
      m_busy[0] = 0; m_busy[1] = 0;
      sb_q.delete();
   endtask

   task automatic drive(input logic v, input logic vc, input logic h, input logic t,
                        input logic [FLIT_W-1:0] f, input logic cv, input logic cvc);
      in_valid = v; in_vc = vc; in_head = h; in_tail = t; in_flit = f;
      credit_valid = cv; credit_vc = cvc;
   endtask

   // Advance one edge, updating the reference model from the driven inputs.
   task automatic step();
      bit    legal, acc, dec, inc;
      int    vi;
      flit_t e;
      @(posedge clk);
      vi    = int'(in_vc);
      legal = in_head ? !m_busy[vi] : m_busy[vi];
      acc   = in_valid && legal && (m_cnt[vi] != 0);
      for (int v = 0; v < 2; v++) begin
         dec = acc && (vi == v);
         inc = credit_valid && (int'(credit_vc) == v);
         if (dec && !inc) m_cnt[v] = m_cnt[v] - 1;
         else if (inc && !dec && m_cnt[v] < 4) m_cnt[v] = m_cnt[v] + 1;
      end
      if (acc) begin
         if (in_tail)      m_busy[vi] = 0;
         else if (in_head) m_busy[vi] = 1;
         e.vc = in_vc; e.head = in_head; e.tail = in_tail; e.flit = in_flit;
         sb_q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, '0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || {out_vc, out_head, out_tail, out_flit} !== '0) begin
         errors++;
         $display("FAIL reset_out got valid=%b fields=%h want 0", out_valid, {out_vc, out_head, out_tail, out_flit});
      end
      checks++;
      if (credit_cnt0 !== 3'd4 || credit_cnt1 !== 3'd4) begin
         errors++;
         $display("FAIL reset_cnt got %0d/%0d want 4/4", credit_cnt0, credit_cnt1);
      end
      checks++;
      if (vc_busy !== 2'b00 || credit_err !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got busy=%b cerr=%b perr=%b want 00/0/0", vc_busy, credit_err, proto_err);
      end
      in_head = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_no_valid got %b want 1", in_ready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, 1, 16'hA000 + 16'(i), 0, 0);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
         end
         step();
         checks++;
         if (credit_cnt0 !== 3'(3 - i)) begin
            errors++;
            $display("FAIL b2b_cnt0[%0d] got %0d want %0d", i, credit_cnt0, 3 - i);
         end
      end
      drive(1, 0, 1, 1, 16'hA004, 0, 0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall got in_ready=%b want 0", in_ready);
      end
      step();
      checks++;
      if (credit_cnt0 !== 3'd0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall_state got cnt0=%0d perr=%b want 0/0", credit_cnt0, proto_err);
      end
   endtask

   task automatic test_credit_return();
      drive(1, 0, 1, 1, 16'hB000, 1, 0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL cret_nobypass got in_ready=%b want 0", in_ready);
      end
      step();
      credit_valid = 1'b0;
      #1;
      checks++;
      if (credit_cnt0 !== 3'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL cret_usable got cnt0=%0d ready=%b want 1/1", credit_cnt0, in_ready);
      end
      step();
      checks++;
      if (credit_cnt0 !== 3'd0) begin
         errors++;
         $display("FAIL cret_consumed got cnt0=%0d want 0", credit_cnt0);
      end
      drive(0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic test_same_cycle();
      drive(1, 1, 1, 1, 16'hC001, 1, 0);
      step();
      drive(1, 1, 1, 1, 16'hC002, 1, 0);
      step();
      checks++;
      if (credit_cnt0 !== 3'd2 || credit_cnt1 !== 3'd2) begin
         errors++;
         $display("FAIL same_diff_vc got %0d/%0d want 2/2", credit_cnt0, credit_cnt1);
      end
      drive(1, 1, 1, 1, 16'hC003, 1, 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL same_vc_ready got %b want 1", in_ready);
      end
      step();
      checks++;
      if (credit_cnt1 !== 3'd2 || credit_cnt0 !== 3'd2) begin
         errors++;
         $display("FAIL same_vc_net got %0d/%0d want 2/2", credit_cnt0, credit_cnt1);
      end
      drive(1, 0, 1, 1, 16'hC004, 1, 1);
      step();
      checks++;
      if (credit_cnt0 !== 3'd1 || credit_cnt1 !== 3'd3) begin
         errors++;
         $display("FAIL send0_ret1 got %0d/%0d want 1/3", credit_cnt0, credit_cnt1);
      end
      drive(0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic test_protocol();
      drive(1, 0, 1, 0, 16'hD001, 0, 0);
      step();
      checks++;
      if (vc_busy !== 2'b01 || credit_cnt0 !== 3'd0) begin
         errors++;
         $display("FAIL proto_head got busy=%b cnt0=%0d want 01/0", vc_busy, credit_cnt0);
      end
      drive(1, 1, 0, 0, 16'hD002, 1, 0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL proto_body_idle_ready got %b want 0", in_ready);
      end
      step();
      checks++;
      if (proto_err !== 1'b1 || vc_busy !== 2'b01 || credit_cnt1 !== 3'd3) begin
         errors++;
         $display("FAIL proto_body_idle got perr=%b busy=%b cnt1=%0d want 1/01/3", proto_err, vc_busy, credit_cnt1);
      end
      drive(1, 0, 1, 0, 16'hD003, 0, 0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL proto_head_busy got in_ready=%b want 0", in_ready);
      end
      step();
      drive(1, 0, 0, 1, 16'hD004, 0, 0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL proto_tail_ready got %b want 1", in_ready);
      end
      step();
      checks++;
      if (vc_busy !== 2'b00 || credit_cnt0 !== 3'd0) begin
         errors++;
         $display("FAIL proto_tail got busy=%b cnt0=%0d want 00/0", vc_busy, credit_cnt0);
      end
      drive(0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic test_credit_overflow();
      drive(0, 0, 0, 0, '0, 1, 1);
      step();
      drive(1, 1, 1, 1, 16'hE001, 1, 1);
      step();
      checks++;
      if (credit_cnt1 !== 3'd4 || credit_err !== 1'b0) begin
         errors++;
         $display("FAIL full_send_ret got cnt1=%0d cerr=%b want 4/0", credit_cnt1, credit_err);
      end
      drive(0, 0, 0, 0, '0, 1, 1);
      step();
      checks++;
      if (credit_cnt1 !== 3'd4 || credit_err !== 1'b1) begin
         errors++;
         $display("FAIL overflow got cnt1=%0d cerr=%b want 4/1", credit_cnt1, credit_err);
      end
      drive(0, 0, 0, 0, '0, 0, 0);
      repeat (3) step();
      checks++;
      if (credit_err !== 1'b1 || proto_err !== 1'b1) begin
         errors++;
         $display("FAIL sticky got cerr=%b perr=%b want 1/1", credit_err, proto_err);
      end
   endtask

   task automatic test_reset_mid_packet();
      drive(0, 0, 0, 0, '0, 1, 0);
      repeat (2) step();
      drive(1, 0, 1, 0, 16'hF001, 0, 0);
      step();
      checks++;
      if (credit_cnt0 !== 3'd1 || vc_busy !== 2'b01 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL premid got cnt0=%0d busy=%b valid=%b want 1/01/1", credit_cnt0, vc_busy, out_valid);
      end
      drive(0, 0, 0, 0, '0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || credit_cnt0 !== 3'd4 || credit_cnt1 !== 3'd4 || vc_busy !== 2'b00 ||
          credit_err !== 1'b0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got valid=%b cnt=%0d/%0d busy=%b cerr=%b perr=%b want 0 4/4 00 0 0",
                  out_valid, credit_cnt0, credit_cnt1, vc_busy, credit_err, proto_err);
      end
      step();
      rst_n = 1'b1;
      drive(1, 0, 1, 1, 16'hF002, 0, 0);
      step();
      drive(0, 0, 0, 0, '0, 0, 0);
      checks++;
      if (credit_cnt0 !== 3'd3) begin
         errors++;
         $display("FAIL post_reset_send got cnt0=%0d want 3", credit_cnt0);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_credit_return();
      test_same_cycle();
      test_protocol();
      test_credit_overflow();
      test_reset_mid_packet();
      repeat (2) step();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
